// File: rtl/stg_wb_mc_pkg.sv
// Package for the multi-channel writeback stage.
// Holds the result/address widths, the packed writeback entry layout (with
// explicit bit offsets for tools that slice the raw vector) and a small
// round-robin index helper shared by the arbiter.
package stg_wb_mc_pkg;

    localparam int SIZE_DATA   = 24;
    localparam int SIZE_ADDR   = 16;
    localparam int SIZE_OPC    = 6;
    localparam int SIZE_TGT_GP = 4;
    localparam int SIZE_TGT_SR = 3;
    localparam int SIZE_TGT_AR = 3;

    // Field order is MSB first; offsets below are the LSB of each field.
    typedef struct packed {
        logic [SIZE_ADDR-1:0]   pc;
        logic [SIZE_DATA-1:0]   instr;
        logic [SIZE_OPC-1:0]    opc;
        logic [SIZE_TGT_GP-1:0] tgt_gp;
        logic                   gp_we;
        logic [SIZE_TGT_SR-1:0] tgt_sr;
        logic                   sr_we;
        logic [SIZE_TGT_AR-1:0] tgt_ar;
        logic                   ar_we;
        logic [SIZE_DATA-1:0]   result;
        logic [SIZE_ADDR-1:0]   sr_result;
        logic [SIZE_ADDR-1:0]   ar_result;
    } wb_ent_t;

    localparam int SIZE_WB_ENT = $bits(wb_ent_t);

    localparam int OFS_AR_RESULT = 0;
    localparam int OFS_SR_RESULT = OFS_AR_RESULT + SIZE_ADDR;
    localparam int OFS_RESULT    = OFS_SR_RESULT + SIZE_ADDR;
    localparam int OFS_AR_WE     = OFS_RESULT + SIZE_DATA;
    localparam int OFS_TGT_AR    = OFS_AR_WE + 1;
    localparam int OFS_SR_WE     = OFS_TGT_AR + SIZE_TGT_AR;
    localparam int OFS_TGT_SR    = OFS_SR_WE + 1;
    localparam int OFS_GP_WE     = OFS_TGT_SR + SIZE_TGT_SR;
    localparam int OFS_TGT_GP    = OFS_GP_WE + 1;
    localparam int OFS_OPC       = OFS_TGT_GP + SIZE_TGT_GP;
    localparam int OFS_INSTR     = OFS_OPC + SIZE_OPC;
    localparam int OFS_PC        = OFS_INSTR + SIZE_DATA;

    // Channel index 'step' positions after 'base', modulo the channel count.
    function automatic int rr_idx(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/stg_wb_mc_fifo.sv
// wb_fifo: per-channel entry buffer for the writeback stage.
// DEPTH x W storage with extra-MSB read/write pointers (full when the MSBs
// differ and the index bits match). Flush empties the buffer in one cycle
// and overrides any push/pop in the same cycle.
// Ports:
//   iw_clk, iw_rst       clock, async active-high reset
//   iw_push / iw_data    write one entry (ignored when full)
//   iw_pop               drop the head entry (ignored when empty)
//   iw_flush             discard everything
//   ow_data              head entry
//   ow_full, ow_empty    occupancy flags
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         iw_clk,
    input  logic         iw_rst,
    input  logic         iw_push,
    input  logic         iw_pop,
    input  logic         iw_flush,
    input  logic [W-1:0] iw_data,
    output logic [W-1:0] ow_data,
    output logic         ow_full,
    output logic         ow_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign ow_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign ow_empty = (wr_ptr_q == rd_ptr_q);

    // Full is judged on the current count, so a same-cycle pop does not open a slot.
    assign do_push = iw_push & ~ow_full & ~iw_flush;
    assign do_pop  = iw_pop & ~ow_empty & ~iw_flush;

    assign ow_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (iw_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge iw_clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= iw_data;
    end

endmodule

// File: rtl/stg_wb_mc.sv
// stg_wb_mc: multi-channel writeback stage.
// Completed ops from NCH producers are buffered per channel, then one op per
// cycle is retired through a round-robin arbiter onto the GP/SR/AR register
// file write ports. A registered retire/echo bundle and a retire counter feed
// forwarding and trace logic.
// Ports:
//   iw_clk, iw_rst            clock, async active-high reset
//   iw_valid / ow_ready       per-channel handshake for iw_ent
//   iw_ent                    packed entries, channel c at [c*ENT_W +: ENT_W]
//   iw_flush                  discard all buffered entries
//   ow_{gp,sr,ar}_write_*     combinational register-file write ports
//   ow_retire_valid/_ch       registered: an entry retired last cycle, and its channel
//   ow_pc/_instr/_opc/_result registered echo of the last retired entry
//   ow_retire_cnt             retired-entry counter (wraps)
//   ow_busy                   any channel buffer non-empty
module stg_wb_mc
    import stg_wb_mc_pkg::*;
#(
    parameter int          NCH     = 2,
    parameter int          DEPTH   = 4,
    parameter int          DATA_W  = SIZE_DATA,
    parameter int          ADDR_W  = SIZE_ADDR,
    parameter int          ENT_W   = SIZE_WB_ENT,
    // Reset value of the retire counter; nonzero only for trace harnesses
    // that need to see the wrap without retiring 2^32 entries.
    parameter logic [31:0] CNT_RST = '0,
    localparam int         CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic [NCH-1:0]         iw_valid,
    output logic [NCH-1:0]         ow_ready,
    input  logic [NCH*ENT_W-1:0]   iw_ent,
    input  logic                   iw_flush,
    output logic [SIZE_TGT_GP-1:0] ow_gp_write_addr,
    output logic [DATA_W-1:0]      ow_gp_write_data,
    output logic                   ow_gp_write_enable,
    output logic [SIZE_TGT_SR-1:0] ow_sr_write_addr,
    output logic [ADDR_W-1:0]      ow_sr_write_data,
    output logic                   ow_sr_write_enable,
    output logic [SIZE_TGT_AR-1:0] ow_ar_write_addr,
    output logic [ADDR_W-1:0]      ow_ar_write_data,
    output logic                   ow_ar_write_enable,
    output logic                   ow_retire_valid,
    output logic [CH_W-1:0]        ow_retire_ch,
    output logic [ADDR_W-1:0]      ow_pc,
    output logic [DATA_W-1:0]      ow_instr,
    output logic [SIZE_OPC-1:0]    ow_opc,
    output logic [DATA_W-1:0]      ow_result,
    output logic [31:0]            ow_retire_cnt,
    output logic                   ow_busy
);

    logic [NCH-1:0]   full;
    logic [NCH-1:0]   empty;
    logic [NCH-1:0]   push;
    logic [NCH-1:0]   pop;
    logic [ENT_W-1:0] head [NCH];

    logic             gnt_vld;
    logic [CH_W-1:0]  gnt_ch;
    logic [CH_W-1:0]  cand;
    wb_ent_t          gnt_ent;

    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                retire_valid_q, retire_valid_d;
    logic [CH_W-1:0]     retire_ch_q, retire_ch_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [SIZE_OPC-1:0] opc_q, opc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [31:0]         retire_cnt_q, retire_cnt_d;

    assign ow_ready = ~full & {NCH{~iw_flush}};
    assign push     = iw_valid & ow_ready;
    assign ow_busy  = ~&empty;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        wb_fifo #(
            .DEPTH (DEPTH),
            .W     (ENT_W)
        ) u_fifo (
            .iw_clk   (iw_clk),
            .iw_rst   (iw_rst),
            .iw_push  (push[c]),
            .iw_pop   (pop[c]),
            .iw_flush (iw_flush),
            .iw_data  (iw_ent[c*ENT_W +: ENT_W]),
            .ow_data  (head[c]),
            .ow_full  (full[c]),
            .ow_empty (empty[c])
        );
    end

    // Scan starts one past the last winner, so the last winner is visited last.
    // A flush cycle grants nothing: no write escapes while buffers are discarded.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        pop     = '0;
        if (!iw_flush) begin
            for (int k = 1; k <= NCH; k++) begin
                cand = CH_W'(rr_idx(int'(rr_ptr_q), k, NCH));
                if (!gnt_vld && !empty[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = cand;
                end
            end
        end
        if (gnt_vld) pop[gnt_ch] = 1'b1;
    end

    assign gnt_ent = wb_ent_t'(head[gnt_ch]);

    // Only the granted head drives the ports; everything reads zero otherwise.
    assign ow_gp_write_enable = gnt_vld & gnt_ent.gp_we;
    assign ow_gp_write_addr   = gnt_vld ? gnt_ent.tgt_gp : '0;
    assign ow_gp_write_data   = gnt_vld ? gnt_ent.result : '0;
    assign ow_sr_write_enable = gnt_vld & gnt_ent.sr_we;
    assign ow_sr_write_addr   = gnt_vld ? gnt_ent.tgt_sr : '0;
    assign ow_sr_write_data   = gnt_vld ? gnt_ent.sr_result : '0;
    assign ow_ar_write_enable = gnt_vld & gnt_ent.ar_we;
    assign ow_ar_write_addr   = gnt_vld ? gnt_ent.tgt_ar : '0;
    assign ow_ar_write_data   = gnt_vld ? gnt_ent.ar_result : '0;

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        retire_valid_d = gnt_vld;
        retire_ch_d    = retire_ch_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        opc_d          = opc_q;
        result_d       = result_q;
        retire_cnt_d   = retire_cnt_q;
        if (gnt_vld) begin
            rr_ptr_d     = gnt_ch;
            retire_ch_d  = gnt_ch;
            pc_d         = gnt_ent.pc;
            instr_d      = gnt_ent.instr;
            opc_d        = gnt_ent.opc;
            result_d     = gnt_ent.result;
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            rr_ptr_q       <= '0;
            retire_valid_q <= 1'b0;
            retire_ch_q    <= '0;
            pc_q           <= '0;
            instr_q        <= '0;
            opc_q          <= '0;
            result_q       <= '0;
            retire_cnt_q   <= CNT_RST;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            retire_valid_q <= retire_valid_d;
            retire_ch_q    <= retire_ch_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            opc_q          <= opc_d;
            result_q       <= result_d;
            retire_cnt_q   <= retire_cnt_d;
        end
    end

    assign ow_retire_valid = retire_valid_q;
    assign ow_retire_ch    = retire_ch_q;
    assign ow_pc           = pc_q;
    assign ow_instr        = instr_q;
    assign ow_opc          = opc_q;
    assign ow_result       = result_q;
    assign ow_retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_stg_wb_mc.sv
module tb_stg_wb_mc;
    import stg_wb_mc_pkg::*;

    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int EW    = SIZE_WB_ENT;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [NCH-1:0]   valid;
    logic [NCH*EW-1:0] ent;
    wb_ent_t          pend [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_ent
        assign ent[c*EW +: EW] = pend[c];
    end

    logic [NCH-1:0] rdy_a, rdy_b;
    logic [3:0]  gpa_a, gpa_b;
    logic [23:0] gpd_a, gpd_b;
    logic        gpe_a, gpe_b;
    logic [2:0]  sra_a, sra_b;
    logic [15:0] srd_a, srd_b;
    logic        sre_a, sre_b;
    logic [2:0]  ara_a, ara_b;
    logic [15:0] ard_a, ard_b;
    logic        are_a, are_b;
    logic        rv_a, rv_b;
    logic        ch_a, ch_b;
    logic [15:0] pc_a, pc_b;
    logic [23:0] ins_a, ins_b;
    logic [5:0]  opc_a, opc_b;
    logic [23:0] res_a, res_b;
    logic [31:0] cnt_a, cnt_b;
    logic        busy_a, busy_b;

    stg_wb_mc #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .iw_clk(clk), .iw_rst(rst), .iw_valid(valid), .ow_ready(rdy_a), .iw_ent(ent),
        .iw_flush(flush),
        .ow_gp_write_addr(gpa_a), .ow_gp_write_data(gpd_a), .ow_gp_write_enable(gpe_a),
        .ow_sr_write_addr(sra_a), .ow_sr_write_data(srd_a), .ow_sr_write_enable(sre_a),
        .ow_ar_write_addr(ara_a), .ow_ar_write_data(ard_a), .ow_ar_write_enable(are_a),
        .ow_retire_valid(rv_a), .ow_retire_ch(ch_a), .ow_pc(pc_a), .ow_instr(ins_a),
        .ow_opc(opc_a), .ow_result(res_a), .ow_retire_cnt(cnt_a), .ow_busy(busy_a)
    );

    // Second instance starts its counter at 2^32-1 to exercise the wrap.
    stg_wb_mc #(.NCH(NCH), .DEPTH(DEPTH), .CNT_RST(32'hFFFF_FFFF)) dut_wrap (
        .iw_clk(clk), .iw_rst(rst), .iw_valid(valid), .ow_ready(rdy_b), .iw_ent(ent),
        .iw_flush(flush),
        .ow_gp_write_addr(gpa_b), .ow_gp_write_data(gpd_b), .ow_gp_write_enable(gpe_b),
        .ow_sr_write_addr(sra_b), .ow_sr_write_data(srd_b), .ow_sr_write_enable(sre_b),
        .ow_ar_write_addr(ara_b), .ow_ar_write_data(ard_b), .ow_ar_write_enable(are_b),
        .ow_retire_valid(rv_b), .ow_retire_ch(ch_b), .ow_pc(pc_b), .ow_instr(ins_b),
        .ow_opc(opc_b), .ow_result(res_b), .ow_retire_cnt(cnt_b), .ow_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference model: one queue per channel plus last-winner / retire state.
    wb_ent_t     mq [NCH][$];
    int          m_rr;
    int          m_g;
    int          m_ch;
    logic        m_rv;
    logic [31:0] m_cnt;
    wb_ent_t     m_echo;
    logic [NCH-1:0] e_rdy;
    wb_ent_t     e_head;
    logic        e_busy;
    bit          acc [NCH];

    bit          collect;
    int          seen_ch [$];
    int          n_acc0;
    int          n_ret0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic wb_ent_t rand_ent();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return wb_ent_t'(r[EW-1:0]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_rr   = 0;
        m_ch   = 0;
        m_rv   = 1'b0;
        m_cnt  = '0;
        m_echo = '0;
    endtask

    task automatic cmp_dut(input string t, input logic [NCH-1:0] rdy,
                           input logic gpe, input logic [3:0] gpa, input logic [23:0] gpd,
                           input logic sre, input logic [2:0] sra, input logic [15:0] srd,
                           input logic are, input logic [2:0] ara, input logic [15:0] ard,
                           input logic rv, input logic ch, input logic [15:0] pc,
                           input logic [23:0] ins, input logic [5:0] opc, input logic [23:0] res,
                           input logic [31:0] cnt, input logic [31:0] cnt_off, input logic busy);
        logic [31:0] ec;
        ec = m_cnt + cnt_off;
        chk({t, "ready"},   64'(rdy), 64'(e_rdy));
        chk({t, "gp_en"},   64'(gpe), 64'(e_head.gp_we));
        chk({t, "gp_addr"}, 64'(gpa), 64'(e_head.tgt_gp));
        chk({t, "gp_data"}, 64'(gpd), 64'(e_head.result));
        chk({t, "sr_en"},   64'(sre), 64'(e_head.sr_we));
        chk({t, "sr_addr"}, 64'(sra), 64'(e_head.tgt_sr));
        chk({t, "sr_data"}, 64'(srd), 64'(e_head.sr_result));
        chk({t, "ar_en"},   64'(are), 64'(e_head.ar_we));
        chk({t, "ar_addr"}, 64'(ara), 64'(e_head.tgt_ar));
        chk({t, "ar_data"}, 64'(ard), 64'(e_head.ar_result));
        chk({t, "rv"},      64'(rv),  64'(m_rv));
        chk({t, "ch"},      64'(ch),  64'(m_ch));
        chk({t, "pc"},      64'(pc),  64'(m_echo.pc));
        chk({t, "instr"},   64'(ins), 64'(m_echo.instr));
        chk({t, "opc"},     64'(opc), 64'(m_echo.opc));
        chk({t, "result"},  64'(res), 64'(m_echo.result));
        chk({t, "cnt"},     64'(cnt), 64'(ec));
        chk({t, "busy"},    64'(busy), 64'(e_busy));
    endtask

    // Sample 1 time unit after the negedge drive and compare against the model.
    task automatic settle();
        int tot;
        #1;
        if (rst) model_reset();
        m_g = -1;
        tot = 0;
        for (int c = 0; c < NCH; c++) begin
            e_rdy[c] = (mq[c].size() < DEPTH) && !flush;
            tot += mq[c].size();
        end
        if (!flush) begin
            for (int k = 1; k <= NCH; k++) begin
                int ch;
                ch = (m_rr + k) % NCH;
                if (m_g < 0 && mq[ch].size() != 0) m_g = ch;
            end
        end
        e_head = (m_g >= 0) ? mq[m_g][0] : '0;
        e_busy = (tot != 0);
        cmp_dut("a_", rdy_a, gpe_a, gpa_a, gpd_a, sre_a, sra_a, srd_a, are_a, ara_a, ard_a,
                rv_a, ch_a, pc_a, ins_a, opc_a, res_a, cnt_a, 32'd0, busy_a);
        cmp_dut("b_", rdy_b, gpe_b, gpa_b, gpd_b, sre_b, sra_b, srd_b, are_b, ara_b, ard_b,
                rv_b, ch_b, pc_b, ins_b, opc_b, res_b, cnt_b, 32'hFFFF_FFFF, busy_b);
        if (collect && rv_a) seen_ch.push_back(int'(ch_a));
        if (rv_a && ch_a == 1'b0) n_ret0++;
    endtask

    // Apply what the clock edge does, then move to the next negedge.
    task automatic advance();
        for (int c = 0; c < NCH; c++) acc[c] = 1'b0;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_rv = 1'b0;
        end else begin
            if (m_g >= 0) begin
                m_echo = mq[m_g].pop_front();
                m_ch   = m_g;
                m_rr   = m_g;
                m_cnt  = m_cnt + 32'd1;
                m_rv   = 1'b1;
            end else begin
                m_rv = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (valid[c] && e_rdy[c]) begin
                    acc[c] = 1'b1;
                    mq[c].push_back(pend[c]);
                end
            end
        end
        if (acc[0]) n_acc0++;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) if (acc[c]) pend[c] = rand_ent();
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic do_reset();
        valid = '0;
        flush = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected summary first");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_ent_t e;
        bit      saw_full;
        int      wr_after;

        n_chk   = 0;
        n_fail  = 0;
        collect = 1'b0;
        n_acc0  = 0;
        n_ret0  = 0;
        rst     = 1'b1;
        flush   = 1'b0;
        valid   = '0;
        for (int c = 0; c < NCH; c++) pend[c] = rand_ent();
        model_reset();
        @(negedge clk);

        // Power-on reset values
        settle();
        chk("por_ready", 64'(rdy_a), 64'(2'b11));
        chk("por_cnt", 64'(cnt_a), 64'd0);
        chk("por_cnt_wrapinst", 64'(cnt_b), 64'hFFFF_FFFF);
        advance();
        rst = 1'b0;

        // Single GP op on ch0
        e = '0;
        e.tgt_gp = 4'd5;
        e.result = 24'h00ABCD;
        e.gp_we  = 1'b1;
        pend[0]  = e;
        valid    = 2'b01;
        tick();
        valid = '0;
        settle();
        chk("single_gp_en", 64'(gpe_a), 64'd1);
        chk("single_gp_addr", 64'(gpa_a), 64'd5);
        chk("single_gp_data", 64'(gpd_a), 64'h00ABCD);
        advance();
        settle();
        chk("single_result", 64'(res_a), 64'h00ABCD);
        chk("single_rv", 64'(rv_a), 64'd1);
        advance();

        // Fairness: both channels push 4 back-to-back
        do_reset();
        seen_ch.delete();
        collect = 1'b1;
        valid = 2'b11;
        repeat (4) tick();
        valid = '0;
        repeat (8) tick();
        collect = 1'b0;
        chk("fair_n_retired", 64'(seen_ch.size()), 64'd8);
        for (int i = 0; i < seen_ch.size() && i < 8; i++)
            chk($sformatf("fair_ch_%0d", i), 64'(seen_ch[i]), 64'((i % 2 == 0) ? 1 : 0));
        chk("fair_cnt", 64'(cnt_a), 64'd8);

        // Full channel: ch0 outpaces its share of grants
        do_reset();
        saw_full = 1'b0;
        n_acc0 = 0;
        n_ret0 = 0;
        valid = 2'b11;
        repeat (14) begin
            settle();
            if (valid[0] && !rdy_a[0]) saw_full = 1'b1;
            advance();
        end
        valid = '0;
        repeat (14) tick();
        chk("full_seen_not_ready", 64'(saw_full), 64'd1);
        chk("full_ch0_all_retired", 64'(n_ret0), 64'(n_acc0));

        // Flush with entries queued
        do_reset();
        valid = 2'b11;
        repeat (3) tick();
        valid = '0;
        flush = 1'b1;
        settle();
        chk("flush_gp_en", 64'(gpe_a), 64'd0);
        chk("flush_sr_en", 64'(sre_a), 64'd0);
        chk("flush_ar_en", 64'(are_a), 64'd0);
        chk("flush_busy_before", 64'(busy_a), 64'd1);
        chk("flush_cnt_before", 64'(cnt_a), 64'd2);
        advance();
        flush = 1'b0;
        settle();
        chk("flush_busy_after", 64'(busy_a), 64'd0);
        chk("flush_rv_after", 64'(rv_a), 64'd0);
        chk("flush_cnt_after", 64'(cnt_a), 64'd2);
        advance();

        // Mixed targets and counter wrap
        do_reset();
        e = '0;
        e.tgt_gp    = 4'd9;
        e.result    = 24'h123456;
        e.gp_we     = 1'b1;
        e.tgt_sr    = 3'd3;
        e.sr_result = 16'hBEEF;
        e.sr_we     = 1'b1;
        e.tgt_ar    = 3'd6;
        e.ar_we     = 1'b0;
        pend[1] = e;
        valid = 2'b10;
        tick();
        valid = '0;
        settle();
        chk("mixed_gp_en", 64'(gpe_a), 64'd1);
        chk("mixed_sr_en", 64'(sre_a), 64'd1);
        chk("mixed_ar_en", 64'(are_a), 64'd0);
        chk("mixed_sr_addr", 64'(sra_a), 64'd3);
        chk("mixed_sr_data", 64'(srd_a), 64'hBEEF);
        advance();
        settle();
        chk("mixed_gp_en_off", 64'(gpe_a), 64'd0);
        chk("mixed_sr_en_off", 64'(sre_a), 64'd0);
        chk("wrap_cnt", 64'(cnt_b), 64'd0);
        chk("wrap_cnt_plain", 64'(cnt_a), 64'd1);
        advance();

        // Reset mid-stream with 3 entries queued
        do_reset();
        valid = 2'b11;
        repeat (2) tick();
        valid = '0;
        rst = 1'b1;
        settle();
        chk("rst_gp_en", 64'(gpe_a), 64'd0);
        chk("rst_sr_en", 64'(sre_a), 64'd0);
        chk("rst_ar_en", 64'(are_a), 64'd0);
        chk("rst_ready", 64'(rdy_a), 64'(2'b11));
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        advance();
        rst = 1'b0;
        wr_after = 0;
        repeat (4) begin
            settle();
            if (gpe_a || sre_a || are_a) wr_after++;
            advance();
        end
        chk("rst_no_write_after", 64'(wr_after), 64'd0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 700; i++) begin
            for (int c = 0; c < NCH; c++) valid[c] = ($urandom_range(0, 99) < 65);
            flush = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            tick();
        end
        valid = '0;
        flush = 1'b0;
        rst   = 1'b0;
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
